// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and frame constants
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    localparam int DATA_BITS              = 8;
    localparam int DEFAULT_CLOCKS_PER_BIT = 868;

endpackage

// File: rtl/baud_counter.sv
// rtl/baud_counter.sv - bit-period counter with explicit clear and bit_done pulse
module baud_counter #(
    parameter int LIMIT = 868,
    parameter int WIDTH = $clog2(LIMIT)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q;

    assign bit_done = (count_q == LAST);

    // Count system clocks within a bit; restart at the bit boundary or when cleared.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (bit_done) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/transmitter.sv
// rtl/transmitter.sv - UART 8N1 transmitter with valid/ready byte input
module transmitter
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
    parameter int STOP_BITS      = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       ready,
    output logic       serial_connection,
    output logic       busy
);

    if (CLOCKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_cfg_error
        $error("transmitter: CLOCKS_PER_BIT must be >= 2 and STOP_BITS must be 1 or 2");
    end

    // Wide enough for the longest stop period so one counter width serves every bit type.
    localparam int          CNT_W     = $clog2(STOP_BITS * CLOCKS_PER_BIT);
    localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_t state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic        line_q;
    logic        ready_q;
    logic        busy_q;
    logic        bit_done;

    // The counter is held at zero while idle, so it starts fresh on the accept edge.
    baud_counter #(
        .LIMIT (CLOCKS_PER_BIT),
        .WIDTH (CNT_W)
    ) u_baud_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_q == IDLE),
        .bit_done (bit_done)
    );

    assign ready             = ready_q;
    assign busy              = busy_q;
    assign serial_connection = line_q;

    // Frame sequencer; the line is registered from the current state, so each bit appears one cycle after its state is entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            line_q    <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    line_q <= 1'b1;
                    if (data_valid && ready_q) begin
                        shift_q <= data;
                        state_q <= START;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    line_q <= 1'b0;
                    if (bit_done) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                    end
                end
                DATA: begin
                    line_q <= shift_q[bit_idx_q];
                    if (bit_done) begin
                        if (bit_idx_q == LAST_DATA) begin
                            state_q   <= STOP;
                            bit_idx_q <= '0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    // The bit index doubles as the stop-bit count.
                    line_q <= 1'b1;
                    if (bit_done) begin
                        if (bit_idx_q == LAST_STOP) begin
                            state_q   <= IDLE;
                            bit_idx_q <= '0;
                            ready_q   <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    line_q  <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// tb/tb_transmitter.sv - table-driven self-checking bench for transmitter
module tb_transmitter;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data1, data2;
    logic       dv1, dv2;
    logic       ready1, ser1, busy1;
    logic       ready2, ser2, busy2;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int last_accept = 0;

    transmitter #(.CLOCKS_PER_BIT(4), .STOP_BITS(1)) dut1 (
        .clock             (clock),
        .reset             (reset),
        .data              (data1),
        .data_valid        (dv1),
        .ready             (ready1),
        .serial_connection (ser1),
        .busy              (busy1)
    );

    transmitter #(.CLOCKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .clock             (clock),
        .reset             (reset),
        .data              (data2),
        .data_valid        (dv2),
        .ready             (ready2),
        .serial_connection (ser2),
        .busy              (busy2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         which;
        logic [7:0] d;
        bit         hold;
        logic [7:0] next_d;
        int         pulse_c;
        int         abort_c;
        int         len;
        int         period;
        logic [10:0] frame;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int which, input logic [7:0] d, input logic v);
        if (which == 1) begin
            data2 = d;
            dv2   = v;
        end else begin
            data1 = d;
            dv1   = v;
        end
    endtask

    task automatic sample(input int which, output logic ln, output logic rdy, output logic bsy);
        ln  = (which == 1) ? ser2   : ser1;
        rdy = (which == 1) ? ready2 : ready1;
        bsy = (which == 1) ? busy2  : busy1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         waited = 0;
        int         mism = 0;
        logic       ln, rdy, bsy;
        logic [7:0] rx = 8'h00;
        bit         aborted = 0;

        sample(v.which, ln, rdy, bsy);
        while (rdy !== 1'b1 && waited < 200) begin
            tick();
            waited++;
            sample(v.which, ln, rdy, bsy);
        end
        check($sformatf("ready_wait[%0d]", idx), (waited < 200), 1);

        drive(v.which, v.d, 1'b1);
        tick();
        sample(v.which, ln, rdy, bsy);
        check($sformatf("accept[%0d]", idx), {ln, rdy, bsy}, 3'b101);
        if (v.period != 0)
            check($sformatf("period[%0d]", idx), cyc - last_accept, v.period);
        last_accept = cyc;

        if (v.hold) drive(v.which, v.next_d, 1'b1);
        else        drive(v.which, 8'hC3, 1'b0);

        for (int c = 1; c <= v.len; c++) begin
            if (c == v.abort_c) reset = 1'b1;
            if (v.pulse_c != 0 && c == v.pulse_c)     drive(v.which, 8'hFF, 1'b1);
            if (v.pulse_c != 0 && c == v.pulse_c + 1) drive(v.which, 8'hC3, 1'b0);
            tick();
            sample(v.which, ln, rdy, bsy);
            if (c == v.abort_c) begin
                reset = 1'b0;
                check($sformatf("abort_line[%0d]", idx), ln, 1'b1);
                check($sformatf("abort_ready[%0d]", idx), rdy, 1'b1);
                check($sformatf("abort_busy[%0d]", idx), bsy, 1'b0);
                aborted = 1;
                break;
            end
            if (ln !== v.frame[(c - 1) / 4]) mism++;
            if (rdy !== (c == v.len)) mism++;
            if (bsy !== (c != v.len)) mism++;
            if ((c - 1) % 4 == 1 && (c - 1) / 4 >= 1 && (c - 1) / 4 <= 8)
                rx[(c - 1) / 4 - 1] = ln;
        end

        if (!aborted) begin
            check($sformatf("frame_shape[%0d]", idx), mism, 0);
            check($sformatf("decoded[%0d]", idx), rx, v.exp_byte);
        end
    endtask

    initial begin
        int bad = 0;

        //          which d      hold next   pulse abort len period frame                 exp
        vecs[0] = '{0, 8'h55, 1'b0, 8'h00, 0,  0,  40, 0,  11'b11_01010101_0, 8'h55};
        vecs[1] = '{0, 8'hA3, 1'b1, 8'h3C, 0,  0,  40, 0,  11'b11_10100011_0, 8'hA3};
        vecs[2] = '{0, 8'h3C, 1'b0, 8'h00, 0,  0,  40, 41, 11'b11_00111100_0, 8'h3C};
        vecs[3] = '{0, 8'h00, 1'b0, 8'h00, 12, 0,  40, 0,  11'b11_00000000_0, 8'h00};
        vecs[4] = '{0, 8'h81, 1'b0, 8'h00, 0,  15, 40, 0,  11'b11_10000001_0, 8'h00};
        vecs[5] = '{0, 8'h7E, 1'b0, 8'h00, 0,  0,  40, 0,  11'b11_01111110_0, 8'h7E};
        vecs[6] = '{1, 8'h0F, 1'b1, 8'h0F, 0,  0,  44, 0,  11'b11_00001111_0, 8'h0F};
        vecs[7] = '{1, 8'h0F, 1'b0, 8'h00, 0,  0,  44, 45, 11'b11_00001111_0, 8'h0F};
        vecs[8] = '{0, 8'hFF, 1'b0, 8'h00, 0,  0,  40, 0,  11'b11_11111111_0, 8'hFF};

        reset = 1'b1;
        data1 = 8'h00; dv1 = 1'b0;
        data2 = 8'h00; dv2 = 1'b0;
        repeat (3) tick();
        check("reset_line", ser1, 1'b1);
        check("reset_ready", ready1, 1'b1);
        check("reset_busy", busy1, 1'b0);
        check("reset_line_2stop", ser2, 1'b1);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            if (ser1 !== 1'b1 || ready1 !== 1'b1 || busy1 !== 1'b0) bad++;
            if (ser2 !== 1'b1 || ready2 !== 1'b1 || busy2 !== 1'b0) bad++;
        end
        check("idle_hold", bad, 0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
